// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - MD_WIDTH      : default operand / HI / LO width
//   - OP_*          : operation codes presented on Op_in
//   - md_state_e    : control FSM states
//   - is_*_op()     : opcode classification helpers
package muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // Operations that run through the iterative datapath.
    function automatic logic is_iter_op(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_iter_op = 1'b1;
            default:                             is_iter_op = 1'b0;
        endcase
    endfunction

    // Operations that treat operands as two's complement.
    function automatic logic is_signed_op(input logic [3:0] op);
        case (op)
            OP_MULT, OP_DIV, OP_MADD, OP_MSUB: is_signed_op = 1'b1;
            default:                           is_signed_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: unsigned iterative datapath, one step per cycle.
//   Multiply: shift-add, {hi,lo} holds the growing product with the
//             multiplier shifting out of lo.
//   Divide  : restoring divide, hi holds the partial remainder and lo the
//             dividend shifting out / quotient shifting in.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture a_i (multiplier / dividend), b_i
//                   (multiplicand / divisor) and div_i; clear the counter
//   step_i        : perform one iteration and advance the counter
//   div_i         : 1 = divide, 0 = multiply
//   a_i, b_i      : unsigned operand magnitudes
//   hi_o, lo_o    : product {hi,lo} or remainder hi / quotient lo
//   cnt_o         : index of the step executed on the next step_i
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_i,
    input  logic                     step_i,
    input  logic                     div_i,
    input  logic [WIDTH-1:0]         a_i,
    input  logic [WIDTH-1:0]         b_i,
    output logic [WIDTH-1:0]         hi_o,
    output logic [WIDTH-1:0]         lo_o,
    output logic [$clog2(WIDTH)-1:0] cnt_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        div_d = div_q;

        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_q};

        if (load_i) begin
            hi_d  = '0;
            lo_d  = a_i;
            b_d   = b_i;
            cnt_d = '0;
            div_d = div_i;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                // Partial remainder stays below the divisor, so whichever
                // value is kept fits back into WIDTH bits.
                if (!div_trial[WIDTH]) begin
                    hi_d = div_trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

    assign hi_o  = hi_q;
    assign lo_o  = lo_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage multi-cycle multiply/divide unit owning HI/LO.
//   Iterative ops take WIDTH RUN cycles plus one FIX cycle; MTHI/MTLO
//   write in a single cycle.
// Ports:
//   Clk, Rst_n     : clock, asynchronous active-low reset
//   Start_in       : valid muldiv op from ID/EX
//   Op_in          : operation code (muldiv_pkg OP_*)
//   A_in, B_in     : rs / rt operands
//   ReadHiLo_in    : instruction in EX reads HI/LO
//   Flush_in       : squash the in-flight or offered op
//   Busy_out       : iterative op in progress (RUN or FIX)
//   Stall_out      : hold IF/ID and ID/EX
//   Done_out       : one-cycle pulse after an iterative op writes HI/LO
//   HI_out, LO_out : architectural HI / LO
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start_in,
    input  logic [3:0]       Op_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             ReadHiLo_in,
    input  logic             Flush_in,
    output logic             Busy_out,
    output logic             Stall_out,
    output logic             Done_out,
    output logic [WIDTH-1:0] HI_out,
    output logic [WIDTH-1:0] LO_out
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    // Latched per-operation context
    logic [3:0]       op_q;
    logic             neg_main_q;   // negate product / quotient
    logic             neg_rem_q;    // negate remainder
    logic             dz_q;         // divide by zero
    logic [WIDTH-1:0] a_raw_q;

    logic             accept;
    logic             signed_op;
    logic             core_load;
    logic             core_step;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [CW-1:0]    core_cnt;

    logic [2*WIDTH-1:0] prod_mag, prod_signed, hilo_cur, fix_hilo;
    logic [WIDTH-1:0]   quo, rem;

    assign accept    = (state_q == ST_IDLE) && Start_in && !Flush_in;
    assign signed_op = is_signed_op(Op_in);
    assign a_mag     = (signed_op && A_in[WIDTH-1]) ? -A_in : A_in;
    assign b_mag     = (signed_op && B_in[WIDTH-1]) ? -B_in : B_in;
    assign core_load = accept && is_iter_op(Op_in);
    assign core_step = (state_q == ST_RUN) && !Flush_in;

    muldiv_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_i (Clk),
        .rst_ni(Rst_n),
        .load_i(core_load),
        .step_i(core_step),
        .div_i (is_div_op(Op_in)),
        .a_i   (a_mag),
        .b_i   (b_mag),
        .hi_o  (core_hi),
        .lo_o  (core_lo),
        .cnt_o (core_cnt)
    );

    // Sign correction and accumulate, evaluated during FIX.
    always_comb begin
        prod_mag    = {core_hi, core_lo};
        prod_signed = neg_main_q ? -prod_mag : prod_mag;
        hilo_cur    = {hi_q, lo_q};
        quo         = neg_main_q ? -core_lo : core_lo;
        rem         = neg_rem_q  ? -core_hi : core_hi;
        case (op_q)
            OP_MADD, OP_MADDU: fix_hilo = hilo_cur + prod_signed;
            OP_MSUB, OP_MSUBU: fix_hilo = hilo_cur - prod_signed;
            OP_DIV,  OP_DIVU:  fix_hilo = dz_q ? {a_raw_q, {WIDTH{1'b1}}}
                                               : {rem, quo};
            default:           fix_hilo = prod_signed;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (Op_in == OP_MTHI) begin
                        hi_d = A_in;
                    end else if (Op_in == OP_MTLO) begin
                        lo_d = A_in;
                    end else if (is_iter_op(Op_in)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (Flush_in) begin
                    state_d = ST_IDLE;
                end else if (core_cnt == LAST_STEP) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!Flush_in) begin
                    {hi_d, lo_d} = fix_hilo;
                    done_d       = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            op_q       <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            a_raw_q    <= '0;
        end else if (core_load) begin
            op_q       <= Op_in;
            neg_main_q <= signed_op && (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
            neg_rem_q  <= signed_op && A_in[WIDTH-1];
            dz_q       <= is_div_op(Op_in) && (B_in == '0);
            a_raw_q    <= A_in;
        end
    end

    assign Busy_out  = (state_q != ST_IDLE);
    assign Stall_out = Busy_out && (Start_in || ReadHiLo_in);
    assign Done_out  = done_q;
    assign HI_out    = hi_q;
    assign LO_out    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        Clk;
    logic        Rst_n;
    logic        Start_in;
    logic [3:0]  Op_in;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic        ReadHiLo_in;
    logic        Flush_in;
    logic        Busy_out;
    logic        Stall_out;
    logic        Done_out;
    logic [31:0] HI_out;
    logic [31:0] LO_out;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Start_in   (Start_in),
        .Op_in      (Op_in),
        .A_in       (A_in),
        .B_in       (B_in),
        .ReadHiLo_in(ReadHiLo_in),
        .Flush_in   (Flush_in),
        .Busy_out   (Busy_out),
        .Stall_out  (Stall_out),
        .Done_out   (Done_out),
        .HI_out     (HI_out),
        .LO_out     (LO_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every Done pulse is matched against the oldest expectation.
    always @(negedge Clk) begin
        if (Rst_n === 1'b1 && Done_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got Done=1 expected no pending op");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("op%0d_HI", e.tag), HI_out, e.hi);
                check($sformatf("op%0d_LO", e.tag), LO_out, e.lo);
            end
        end
    end

    // Offer one op for one cycle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic flush);
        @(negedge Clk);
        Start_in = 1'b1;
        Op_in    = op;
        A_in     = a;
        B_in     = b;
        Flush_in = flush;
        @(negedge Clk);
        Start_in = 1'b0;
        Flush_in = 1'b0;
    endtask

    // Issue an iterative op, expect it to stay busy for 33 cycles.
    task automatic run_op(input int tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        exp_t e;
        e.hi = eh; e.lo = el; e.tag = tag;
        exp_q.push_back(e);
        issue(op, a, b, 1'b0);
        n = 0;
        while (Busy_out && n < 100) begin
            n++;
            @(negedge Clk);
        end
        check($sformatf("op%0d_busy_cycles", tag), 32'(n), 32'd33);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    initial begin
        int n;
        Rst_n       = 1'b0;
        Start_in    = 1'b0;
        Op_in       = '0;
        A_in        = '0;
        B_in        = '0;
        ReadHiLo_in = 1'b0;
        Flush_in    = 1'b0;
        wait_cycles(3);
        check("rst_HI", HI_out, 32'h0);
        check("rst_LO", LO_out, 32'h0);
        check("rst_Busy", 32'(Busy_out), 32'h0);
        check("rst_Done", 32'(Done_out), 32'h0);
        check("rst_Stall", 32'(Stall_out), 32'h0);
        Rst_n = 1'b1;
        wait_cycles(1);

        // Multiply and divide vectors
        run_op(1,  OP_MULT,  32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run_op(2,  OP_MULTU, 32'hFFFF_FFFF, 32'd5,         32'h0000_0004, 32'hFFFF_FFFB);
        run_op(3,  OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_000C);
        run_op(4,  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(5,  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op(6,  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op(7,  OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);
        run_op(8,  OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
        run_op(9,  OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // MTLO / MTHI take effect one edge after being offered
        issue(OP_MTLO, 32'h10, 32'h0, 1'b0);
        check("mtlo_LO", LO_out, 32'h10);
        check("mtlo_Busy", 32'(Busy_out), 32'h0);
        issue(OP_MTHI, 32'h0, 32'h0, 1'b0);
        check("mthi_HI", HI_out, 32'h0);

        // Accumulating ops build on the current HI/LO
        run_op(10, OP_MADD,  32'd3,         32'd4,         32'h0000_0000, 32'h0000_001C);
        run_op(11, OP_MSUBU, 32'd1,         32'h1D,        32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(12, OP_MSUB,  32'd2,         32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0005);
        run_op(13, OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0006);

        // Stall: only dependent or muldiv instructions wait while busy.
        // A Start offered while busy must be ignored (result stays 7*6).
        begin
            exp_t e;
            e.hi = 32'h0; e.lo = 32'd42; e.tag = 14;
            exp_q.push_back(e);
        end
        issue(OP_MULT, 32'd7, 32'd6, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1 check("stall_idle_independent", 32'(Stall_out), 32'h0);
            @(negedge Clk);
        end
        ReadHiLo_in = 1'b1;
        #1 check("stall_readhilo", 32'(Stall_out), 32'h1);
        @(negedge Clk);
        Start_in = 1'b1; Op_in = OP_MULTU; A_in = 32'hFFFF_FFFF; B_in = 32'hFFFF_FFFF;
        #1 check("stall_start_busy", 32'(Stall_out), 32'h1);
        @(negedge Clk);
        Start_in = 1'b0;
        n = 0;
        while (Busy_out && n < 100) begin
            if (Stall_out !== 1'b1) begin
                check("stall_hold", 32'(Stall_out), 32'h1);
            end
            n++;
            @(negedge Clk);
        end
        check("stall_busy_dropped", 32'(Busy_out), 32'h0);
        #1 check("stall_released", 32'(Stall_out), 32'h0);
        ReadHiLo_in = 1'b0;
        wait_cycles(3);
        check("ignored_start_Busy", 32'(Busy_out), 32'h0);

        // Flush mid-RUN: back to IDLE, HI/LO untouched, no Done
        issue(OP_MTHI, 32'h0000_AAAA, 32'h0, 1'b0);
        issue(OP_MTLO, 32'h0000_5555, 32'h0, 1'b0);
        issue(OP_MULT, 32'd3, 32'd3, 1'b0);
        wait_cycles(10);
        Flush_in = 1'b1;
        @(negedge Clk);
        Flush_in = 1'b0;
        check("flush_Busy", 32'(Busy_out), 32'h0);
        wait_cycles(40);
        check("flush_HI", HI_out, 32'h0000_AAAA);
        check("flush_LO", LO_out, 32'h0000_5555);

        // Flush with Start in the same cycle: op not accepted
        issue(OP_MULT, 32'd3, 32'd3, 1'b1);
        check("flush_start_Busy", 32'(Busy_out), 32'h0);
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b1);
        check("flush_mthi_HI", HI_out, 32'h0000_AAAA);

        // Undefined opcode is ignored
        issue(4'hC, 32'h1234_5678, 32'h1, 1'b0);
        check("undef_Busy", 32'(Busy_out), 32'h0);
        check("undef_HI", HI_out, 32'h0000_AAAA);
        check("undef_LO", LO_out, 32'h0000_5555);

        // Reset mid-operation clears HI/LO immediately, no Done afterwards
        issue(OP_MULT, 32'd9, 32'd9, 1'b0);
        wait_cycles(20);
        Rst_n = 1'b0;
        #1;
        check("midrst_HI", HI_out, 32'h0);
        check("midrst_LO", LO_out, 32'h0);
        check("midrst_Busy", 32'(Busy_out), 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        wait_cycles(40);
        check("midrst_still_idle", 32'(Busy_out), 32'h0);

        // Unit still operational after reset
        run_op(15, OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
        wait_cycles(2);
        check("pending_expectations", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
